adder_tree_operand_packer: RTL and testbench

- Upstream feeder for the 8-input, 3-level adder tree.
- Accepts a serial stream of 17-bit operands on a valid/ready handshake and packs them into 8-lane frames.
- Presents each frame as 8 parallel operands with a valid/ready output handshake.
- Double-buffered (fill bank + output bank), so the input stream keeps flowing while the downstream stage holds a frame.

---
 rtl/adder_tree_operand_packer_if.sv | 41 ++++
 rtl/adder_tree_operand_packer.sv | 120 ++++++++++++
 tb/tb_adder_tree_operand_packer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/adder_tree_operand_packer_if.sv
// Handshake bundle between the serial operand stream, the packer and the
// 8-lane adder tree input. The master drives beats and consumes frames;
// the slave (the packer) accepts beats and presents frames.
interface adder_tree_operand_packer_if #(
   parameter int WIDTH   = 17,
   parameter int FRAME_W = 8
);
   logic [WIDTH-1:0]   in_data;
   logic               in_valid;
   logic               in_last;
   logic               in_ready;

   logic [WIDTH-1:0]   osum0_0_0_0;
   logic [WIDTH-1:0]   osum0_0_0_1;
   logic [WIDTH-1:0]   osum0_0_1_0;
   logic [WIDTH-1:0]   osum0_0_1_1;
   logic [WIDTH-1:0]   osum0_1_0_0;
   logic [WIDTH-1:0]   osum0_1_0_1;
   logic [WIDTH-1:0]   osum0_1_1_0;
   logic [WIDTH-1:0]   osum0_1_1_1;
   logic               out_valid;
   logic               out_ready;
   logic [3:0]         out_count;
   logic [FRAME_W-1:0] out_frame;

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready,
      input  osum0_0_0_0, osum0_0_0_1, osum0_0_1_0, osum0_0_1_1,
      input  osum0_1_0_0, osum0_1_0_1, osum0_1_1_0, osum0_1_1_1,
      input  out_valid, out_count, out_frame
   );

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready,
      output osum0_0_0_0, osum0_0_0_1, osum0_0_1_0, osum0_0_1_1,
      output osum0_1_0_0, osum0_1_0_1, osum0_1_1_0, osum0_1_1_1,
      output out_valid, out_count, out_frame
   );
endinterface

// File: rtl/adder_tree_operand_packer.sv
// Packs a serial stream of operands into 8-lane frames for the adder tree.
// A fill bank collects beats while the output bank holds the frame being
// offered downstream; a completed frame that cannot move yet waits in the
// fill bank (pend) and stalls the input until the output bank frees up.
module adder_tree_operand_packer #(
   parameter int WIDTH   = 17,
   parameter int FRAME_W = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   adder_tree_operand_packer_if.slave  bus
);

   typedef logic [WIDTH-1:0] lane_t;

   lane_t              fill_q [8];
   lane_t              fill_d [8];
   lane_t              obank_q [8];
   lane_t              obank_d [8];
   logic [3:0]         fill_cnt_q, fill_cnt_d;
   logic               pend_q, pend_d;
   logic               out_valid_q, out_valid_d;
   logic [3:0]         out_count_q, out_count_d;
   logic [FRAME_W-1:0] out_frame_q, out_frame_d;
   logic [FRAME_W-1:0] seq_q, seq_d;

   logic               in_ready;
   logic               beat_acc;
   logic               beat_done;
   logic               out_free;
   logic [2:0]         beat_idx;

   // Handshake decode, beat placement and bank movement for the next edge.
   always_comb begin
      in_ready    = !pend_q && !rst;
      beat_acc    = bus.in_valid && in_ready;
      beat_idx    = fill_cnt_q[2:0];
      beat_done   = beat_acc && ((beat_idx == 3'd7) || bus.in_last);
      out_free    = !out_valid_q || bus.out_ready;

      fill_d      = fill_q;
      obank_d     = obank_q;
      fill_cnt_d  = fill_cnt_q;
      pend_d      = pend_q;
      out_valid_d = out_valid_q && !bus.out_ready;
      out_count_d = out_count_q;
      out_frame_d = out_frame_q;
      seq_d       = seq_q;

      if (pend_q && out_free) begin
         // Parked frame moves to the output bank; lanes past its count are
         // already zero because the fill bank is cleared after every frame.
         obank_d     = fill_q;
         out_count_d = fill_cnt_q;
         out_valid_d = 1'b1;
         out_frame_d = seq_q;
         seq_d       = seq_q + 1'b1;
         for (int i = 0; i < 8; i++) fill_d[i] = '0;
         fill_cnt_d  = 4'd0;
         pend_d      = 1'b0;
      end else if (beat_acc) begin
         fill_d[beat_idx] = bus.in_data;
         if (beat_done) begin
            if (out_free) begin
               obank_d     = fill_d;
               out_count_d = {1'b0, beat_idx} + 4'd1;
               out_valid_d = 1'b1;
               out_frame_d = seq_q;
               seq_d       = seq_q + 1'b1;
               for (int i = 0; i < 8; i++) fill_d[i] = '0;
               fill_cnt_d  = 4'd0;
            end else begin
               fill_cnt_d  = {1'b0, beat_idx} + 4'd1;
               pend_d      = 1'b1;
            end
         end else begin
            fill_cnt_d = fill_cnt_q + 4'd1;
         end
      end
   end

   // State registers; reset discards partial, pending and output frames.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            fill_q[i]  <= '0;
            obank_q[i] <= '0;
         end
         fill_cnt_q  <= 4'd0;
         pend_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_count_q <= 4'd0;
         out_frame_q <= '0;
         seq_q       <= '0;
      end else begin
         fill_q      <= fill_d;
         obank_q     <= obank_d;
         fill_cnt_q  <= fill_cnt_d;
         pend_q      <= pend_d;
         out_valid_q <= out_valid_d;
         out_count_q <= out_count_d;
         out_frame_q <= out_frame_d;
         seq_q       <= seq_d;
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_count   = out_count_q;
   assign bus.out_frame   = out_frame_q;
   assign bus.osum0_0_0_0 = obank_q[0];
   assign bus.osum0_0_0_1 = obank_q[1];
   assign bus.osum0_0_1_0 = obank_q[2];
   assign bus.osum0_0_1_1 = obank_q[3];
   assign bus.osum0_1_0_0 = obank_q[4];
   assign bus.osum0_1_0_1 = obank_q[5];
   assign bus.osum0_1_1_0 = obank_q[6];
   assign bus.osum0_1_1_1 = obank_q[7];

endmodule

// File: tb/tb_adder_tree_operand_packer.sv
// Directed bench for the adder tree operand packer: reset state, full and
// short frames, backpressure with a parked frame, no-bubble reloads,
// reset mid-frame and sequence counter wrap.
module tb_adder_tree_operand_packer;

   localparam int WIDTH   = 17;
   localparam int FRAME_W = 8;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   adder_tree_operand_packer_if #(.WIDTH(WIDTH), .FRAME_W(FRAME_W)) bus ();

   adder_tree_operand_packer #(.WIDTH(WIDTH), .FRAME_W(FRAME_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] lane(input int k);
      case (k)
         0:       return bus.osum0_0_0_0;
         1:       return bus.osum0_0_0_1;
         2:       return bus.osum0_0_1_0;
         3:       return bus.osum0_0_1_1;
         4:       return bus.osum0_1_0_0;
         5:       return bus.osum0_1_0_1;
         6:       return bus.osum0_1_1_0;
         default: return bus.osum0_1_1_1;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_frame(input string tag, input logic [WIDTH-1:0] e [8],
                              input int cnt, input int frm);
      check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
      for (int i = 0; i < 8; i++)
         check($sformatf("%s.lane%0d", tag, i), 32'(lane(i)), 32'(e[i]));
      check({tag, ".count"}, 32'(bus.out_count), 32'(cnt));
      check({tag, ".frame"}, 32'(bus.out_frame), 32'(frm));
   endtask

   task automatic beat(input logic [WIDTH-1:0] d, input logic last);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      logic [WIDTH-1:0] e [8];
      logic [WIDTH-1:0] sv [3];
      int               stalls;

      n_chk = 0;
      n_err = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      // reset state
      tick();
      tick();
      check("rst.valid", 32'(bus.out_valid), 32'd0);
      check("rst.count", 32'(bus.out_count), 32'd0);
      check("rst.frame", 32'(bus.out_frame), 32'd0);
      check("rst.in_ready_hi", 32'(bus.in_ready), 32'd0);
      for (int i = 0; i < 8; i++) check($sformatf("rst.lane%0d", i), 32'(lane(i)), 32'd0);
      rst = 1'b0;
      #1;
      check("rst.in_ready_lo", 32'(bus.in_ready), 32'd1);

      // full frame, out_ready=1
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 7) check("full.pre_valid", 32'(bus.out_valid), 32'd0);
         beat(WIDTH'(i + 1), 1'b0);
      end
      for (int i = 0; i < 8; i++) e[i] = WIDTH'(i + 1);
      check_frame("full", e, 8, 0);
      tick();
      check("full.consumed", 32'(bus.out_valid), 32'd0);
      check("full.hold_lane0", 32'(lane(0)), 32'd1);

      // short frame with in_last on the third beat
      sv[0] = 17'h1FFFF; sv[1] = 17'h00001; sv[2] = 17'h0ABCD;
      beat(sv[0], 1'b0);
      beat(sv[1], 1'b0);
      beat(sv[2], 1'b1);
      for (int i = 0; i < 8; i++) e[i] = (i < 3) ? sv[i] : '0;
      check_frame("short", e, 3, 1);
      tick();

      // backpressure: frame 0 held, frame 1 parked
      do_reset();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         check($sformatf("bp.in_ready%0d", i), 32'(bus.in_ready), 32'd1);
         beat(WIDTH'(i), 1'b0);
      end
      check("bp.stalled", 32'(bus.in_ready), 32'd0);
      for (int i = 0; i < 8; i++) e[i] = WIDTH'(i);
      check_frame("bp.held", e, 8, 0);
      tick();
      tick();
      check("bp.still_stalled", 32'(bus.in_ready), 32'd0);
      check_frame("bp.held2", e, 8, 0);
      bus.out_ready = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) e[i] = WIDTH'(i + 8);
      check_frame("bp.f1", e, 8, 1);
      check("bp.resume", 32'(bus.in_ready), 32'd1);

      // consume and new single-beat frame at the same edge: no bubble
      sv[0] = 17'h00011; sv[1] = 17'h00022; sv[2] = 17'h00033;
      for (int k = 0; k < 3; k++) begin
         beat(sv[k], 1'b1);
         for (int i = 0; i < 8; i++) e[i] = (i == 0) ? sv[k] : '0;
         check_frame($sformatf("single%0d", k), e, 1, 2 + k);
      end
      tick();
      check("single.drain", 32'(bus.out_valid), 32'd0);

      // back-to-back, 24 continuous beats
      do_reset();
      stalls = 0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 24; i++) begin
         if (bus.in_ready !== 1'b1) stalls++;
         bus.in_data = WIDTH'(i);
         tick();
         if (i % 8 == 7) begin
            for (int j = 0; j < 8; j++) e[j] = WIDTH'(i - 7 + j);
            check_frame($sformatf("b2b%0d", i / 8), e, 8, i / 8);
         end
      end
      bus.in_valid = 1'b0;
      check("b2b.stalls", 32'(stalls), 32'd0);

      // reset mid-frame discards the partial fill
      tick();
      for (int i = 0; i < 5; i++) beat(WIDTH'(17'h50 + i), 1'b0);
      do_reset();
      check("mid.valid", 32'(bus.out_valid), 32'd0);
      check("mid.in_ready", 32'(bus.in_ready), 32'd1);
      for (int i = 0; i < 8; i++) begin
         if (i == 3) tick();
         beat(WIDTH'(17'h100 + i), 1'b0);
         if (i == 2) check("mid.early", 32'(bus.out_valid), 32'd0);
      end
      for (int i = 0; i < 8; i++) e[i] = WIDTH'(17'h100 + i);
      check_frame("mid", e, 8, 0);

      // out_frame wrap over 257 frames
      do_reset();
      bus.in_valid = 1'b1;
      for (int f = 0; f < 257; f++) begin
         for (int i = 0; i < 8; i++) begin
            bus.in_data = WIDTH'(f);
            tick();
         end
         if (f >= 254) begin
            check($sformatf("wrap%0d.valid", f), 32'(bus.out_valid), 32'd1);
            check($sformatf("wrap%0d.frame", f), 32'(bus.out_frame), 32'(f % 256));
            check($sformatf("wrap%0d.lane7", f), 32'(lane(7)), 32'(f));
         end
      end
      bus.in_valid = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
